dff_pipe: RTL and testbench
===========================

// Module: dff_pipe
// PURPOSE
// Parametrised successor to the single-stage flop: a DEPTH-stage, WIDTH-bit register
// pipeline with per-stage valid bits, valid/ready backpressure, bubble collapsing and
// synchronous flush. Sits between LED pattern/brightness sources and the PWM/driver
// stage, retiming data across long paths without dropping or duplicating words.
// PARAMETERS
// WIDTH        4   data bits per stage (>=1)
// DEPTH        2   number of register stages (>=1); also max words held
// RESET_VALUE  0   value of every stage data register after reset/flush
// CNT_W        $clog2(DEPTH+1)  width of occupancy count (derived, not overridden)
// PORTS
// clk        in   1       rising-edge clock
// reset      in   1       asynchronous, active-low reset
// clear      in   1       synchronous flush, priority over all transfers
// in_valid   in   1       upstream word present
// in_data    in   WIDTH   upstream word
// in_ready   out  1       block accepts word this cycle (combinational)
// out_valid  out  1       stage DEPTH-1 holds a word
// out_data   out  WIDTH   stage DEPTH-1 data
// out_ready  in   1       downstream accepts word this cycle
// count      out  CNT_W   number of valid stages, 0..DEPTH
// BEHAVIOUR
// - Storage: v[k], d[k] for k=0..DEPTH-1; stage DEPTH-1 drives out_valid/out_data.
// - reset low (async, any time): all v[k]=0, all d[k]=RESET_VALUE, count=0,
//   out_valid=0, out_data=RESET_VALUE. Release takes effect on next clk edge.
// - Ready chain (combinational): rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready;
//   rdy[k] = ~v[k] | rdy[k+1]; in_ready = rdy[0] & ~clear.
// - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready & ~clear.
// - Per edge, clear=0: stage k with rdy[k]=1 loads v[k] <= v[k-1] (in_valid for k=0);
//   d[k] <= d[k-1] (in_data for k=0) only when the source valid is 1, else d[k] holds.
//   Stage with rdy[k]=0 holds v[k] and d[k].
// - Bubble collapse: an empty stage always loads, so words advance into gaps even while
//   out_ready=0; pipeline fills to DEPTH words before in_ready drops.
// - Latency: word accepted into empty pipe appears at out_valid DEPTH cycles later.
//   Throughput: one word/cycle when out_ready held 1.
// - Stall: out_valid & ~out_ready -> out_data stable, no stage data corrupted.
// - Full (count==DEPTH) & out_ready=0 -> in_ready=0. Full & out_ready=1 -> in_ready=1,
//   simultaneous in/out transfer, count unchanged.
// - Empty: out_valid=0, in_ready=1 (unless clear); out_ready ignored.
// - count: registered; +1 on in-only transfer, -1 on out-only, unchanged on both/neither.
// - clear=1: in_ready=0 and output transfer suppressed (out_valid port forced 0 that
//   cycle); next edge all v[k]=0, d[k]=RESET_VALUE, count=0. clear over reset: reset wins.
// - DEPTH=1: single stage, in_ready = ~v[0] | out_ready; full rate with out_ready=1.
// - Ordering: words leave in acceptance order; none dropped, none duplicated.
// TESTING
// 1 Reset: WIDTH=4,DEPTH=3,RESET_VALUE=4'hA, drop reset mid-stream -> out_valid=0,
//   out_data=4'hA, count=0 immediately (async), in_ready=1 after release.
// 2 Latency/throughput: out_ready=1, push 1,2,3,4 back-to-back -> out_valid rises 3
//   cycles after first accept, outputs 1,2,3,4 on consecutive cycles, count peaks 3.
// 3 Fill/stall: out_ready=0, push 5,6,7,8 -> 5,6,7 accepted, in_ready=0 at count=3,
//   out_data=5 stable; release out_ready -> 5,6,7 then 8 accepted, order preserved.
// 4 Full simultaneous: count=3, in_valid=1,out_ready=1 for 4 cycles -> count stays 3,
//   one word in and one out each cycle, in_ready=1 throughout.
// 5 Bubble collapse: push 9, idle 2 cycles, push B with out_ready=0 -> both held,
//   count=2, 9 then B emitted with no gap once out_ready=1.
// 6 Flush: count=2, assert clear with in_valid=1,out_ready=1 -> in_ready=0, out_valid=0
//   that cycle, no transfers; next cycle count=0, out_data=RESET_VALUE; DEPTH=1 rerun 2,3.

Source files
------------

// File: rtl/dff_pipe.sv
// DEPTH-stage WIDTH-bit register pipeline with per-stage valid bits, valid/ready
// backpressure, bubble collapsing, synchronous flush and an occupancy counter.

module dff_pipe_stage #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             ld,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= 1'b0;
      d <= RESET_VALUE;
    end else if (clear) begin
      v <= 1'b0;
      d <= RESET_VALUE;
    end else if (ld) begin
      v <= src_v;
      // a bubble moving in leaves the old data in place
      if (src_v) d <= src_d;
    end
  end
endmodule

module dff_pipe #(
  parameter int               WIDTH       = 4,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CNT_W       = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);
  logic [DEPTH-1:0]            v, rdy, src_v;
  logic [DEPTH-1:0][WIDTH-1:0] d, src_d;
  logic                        xfer_in, xfer_out;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    if (k == 0) begin : g_head
      assign src_v[k] = in_valid;
      assign src_d[k] = in_data;
    end else begin : g_body
      assign src_v[k] = v[k-1];
      assign src_d[k] = d[k-1];
    end
    // stage k can load unless it and every stage downstream is full and stalled
    assign rdy[k] = ~(&v[DEPTH-1:k]) | out_ready;

    dff_pipe_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stg (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .ld    (rdy[k]),
      .src_v (src_v[k]),
      .src_d (src_d[k]),
      .v     (v[k]),
      .d     (d[k])
    );
  end

  assign in_ready  = rdy[0] & ~clear;
  assign out_valid = v[DEPTH-1] & ~clear;
  assign out_data  = d[DEPTH-1];
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else
      count <= count + CNT_W'(xfer_in) - CNT_W'(xfer_out);
  end
endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench: a DEPTH=3 and a DEPTH=1 pipe share stimulus; each has a
// word-position model, an expected-data queue and a separate output monitor.

module tb_dff_pipe;
  localparam logic [3:0] RV = 4'hA;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 3 : 1;
    logic                     ir, ov;
    logic [3:0]               od;
    logic [$clog2(D+1)-1:0]   cnt;
    int                       pos_q[$];   // stage index of each held word, oldest first
    logic [3:0]               exp_q[$];   // expected output order
    bit                       clean = 1'b1;

    dff_pipe #(.WIDTH(4), .DEPTH(D), .RESET_VALUE(RV)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (ir),
      .out_valid (ov),
      .out_data  (od),
      .out_ready (out_ready),
      .count     (cnt)
    );

    // reference model: check outputs mid-cycle, then advance to the post-edge state
    always @(negedge clk) begin
      bit m_ir, m_ov;
      int lim, np;
      if (!reset) begin
        chk($sformatf("D%0d rst out_valid", D), int'(ov), 0);
        chk($sformatf("D%0d rst out_data", D), int'(od), int'(RV));
        chk($sformatf("D%0d rst count", D), int'(cnt), 0);
        pos_q.delete();
        exp_q.delete();
        clean = 1'b1;
      end else begin
        m_ir = (pos_q.size() < D || out_ready) && !clear;
        m_ov = pos_q.size() > 0 && pos_q[0] == D-1 && !clear;
        chk($sformatf("D%0d in_ready", D), int'(ir), int'(m_ir));
        chk($sformatf("D%0d out_valid", D), int'(ov), int'(m_ov));
        chk($sformatf("D%0d count", D), int'(cnt), pos_q.size());
        if (!m_ov && clean)
          chk($sformatf("D%0d idle out_data", D), int'(od), int'(RV));
        if (clear) begin
          pos_q.delete();
          exp_q.delete();
          clean = 1'b1;
        end else begin
          if (m_ov && out_ready) void'(pos_q.pop_front());
          lim = D-1;
          foreach (pos_q[i]) begin
            np = (pos_q[i] + 1 < lim) ? pos_q[i] + 1 : lim;
            pos_q[i] = np;
            if (np == D-1) clean = 1'b0;
            lim = np - 1;
          end
          if (in_valid && m_ir) begin
            pos_q.push_back(0);
            exp_q.push_back(in_data);
            if (D == 1) clean = 1'b0;
          end
        end
      end
    end

    // monitor: every output transfer must carry the oldest outstanding word
    always @(negedge clk) begin
      #1;
      if (reset && ov && out_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("D%0d unexpected word", D), int'(od), -1);
        end else begin
          chk($sformatf("D%0d out_data", D), int'(od), int'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit v, input logic [3:0] dat, input bit ordy, input bit clr);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = dat;
    out_ready = ordy;
    clear     = clr;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    step(0, 0, 1, 0);
    // back-to-back stream at full rate
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 1, 0);
    repeat (5) step(0, 0, 1, 0);
    // fill under stall, then release
    for (int i = 5; i <= 8; i++) step(1, 4'(i), 0, 0);
    repeat (3) step(1, 8, 0, 0);
    repeat (2) step(1, 8, 1, 0);
    repeat (5) step(0, 0, 1, 0);
    // full with simultaneous in/out
    for (int i = 0; i < 3; i++) step(1, 4'(i + 1), 0, 0);
    for (int i = 0; i < 4; i++) step(1, 4'(i + 12), 1, 0);
    repeat (5) step(0, 0, 1, 0);
    // bubble collapse
    step(1, 9, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(1, 4'hB, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0);
    // flush with traffic pending
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(0, 0, 0, 0);
    step(1, 7, 1, 1);
    repeat (3) step(0, 0, 1, 0);
    // random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 3);
    // asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) step(1, 4'(i + 3), 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 9) < 6, 4'($urandom), $urandom_range(0, 9) < 7, 1'b0);
    repeat (6) step(0, 0, 1, 0);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
